fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
- Drains a FIFO that has one-cycle read latency (`rd_en` in cycle N, data valid in cycle N+1) and presents the data as a valid/ready stream.
- Sits on the read side of the SRAM-backed FIFO. It is the consumer for the FIFO's producer interface.
- A small flop buffer absorbs in-flight reads, so the stream runs at one word per cycle with no bubbles and no data loss under backpressure.

Parameters:
- WIDTH, 8: data width in bits; must match the FIFO.
- BUF_DEPTH, 2: output flop buffer entries; minimum 2, which is required for full throughput.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- fifo_rd_en_o  out  1  read request to the FIFO
- fifo_empty_i  in  1  FIFO empty flag (registered, reflects the previous cycle's reads)
- fifo_data_i  in  WIDTH  FIFO read data, valid only in the cycle after `fifo_rd_en_o`
- m_valid_o  out  1  stream data valid
- m_ready_i  in  1  stream sink ready
- m_data_o  out  WIDTH  stream data

Behaviour:
- Reset values:
  - `fifo_rd_en_o`=0, `m_valid_o`=0, `m_data_o`=0.
  - Buffer count=0, in-flight flag=0, buffer pointers=0.
- Reset mid-operation:
  - Buffered words and any in-flight read are discarded.
  - The capture of the in-flight read is suppressed.
  - No `m_valid_o` in the cycle after reset deasserts.
- In-flight tracking:
  - `inflight_ff` <= `fifo_rd_en_o` each cycle.
  - When `inflight_ff`=1, `fifo_data_i` is written into the buffer tail that cycle, unconditionally.
- Pop:
  - `pop` = `m_valid_o` && `m_ready_i`.
  - `m_valid_o` = (count != 0).
  - `m_data_o` = buffer head entry; combinational from the head register, stable while valid && !ready.
- Read issue:
  - `fifo_rd_en_o` = !`fifo_empty_i` && (count + `inflight_ff` − `pop`) < BUF_DEPTH.
  - This guarantees a slot exists when the data lands.
  - Never asserted while `fifo_empty_i`=1.
- Count update:
  - count_next = count + `inflight_ff` − `pop`.
  - Width is $clog2(BUF_DEPTH+1).
  - Push and pop in the same cycle leave count unchanged.
  - Overflow and underflow are impossible by construction.
- Buffer:
  - Circular, with head/tail pointers wrapping BUF_DEPTH−1 → 0.
  - Non-power-of-2 depths are supported via explicit compare.
- Latency:
  - FIFO non-empty at cycle N → `fifo_rd_en_o` at N → data captured at N+1 → `m_valid_o` at N+2.
- Throughput:
  - Sustained 1 word/cycle while the FIFO is non-empty and `m_ready_i`=1.
- Boundaries:
  - Buffer full with `m_ready_i`=0: no read issued.
  - `m_ready_i` returning high: a read is issued in the same cycle as the pop, so there is no bubble after the first pop.
  - FIFO going empty: `m_valid_o` drops once the buffer drains; no spurious read.
- Ordering: strict FIFO order preserved.

Optional Feature:
- Macro: FIFO_STREAM_READER_STATS_EN.
- When defined, adds output port `stall_cnt_o` [31:0]:
  - Reset 0.
  - Increments each cycle `m_valid_o` && !`m_ready_i`.
  - Saturates at 32'hFFFF_FFFF.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `sram_fifo_pkg`:
  - Typedef `data_t` (logic [WIDTH-1:0] default 8).
  - Localparam helper for count width ($clog2(depth+1)).
  - Shared with the FIFO.
- Sub-module `flop_fifo`:
  - Parameterised WIDTH/DEPTH register buffer.
  - Ports: push, pop, data in, head data out, count.
  - Wraps the pointer and count logic.
  - Top level holds the issue/in-flight control and the optional stats counter.

Test Plan:
- Reset, then FIFO empty for 10 cycles → `fifo_rd_en_o`=0 throughout and `m_valid_o`=0.
- FIFO preloaded with 0x01..0x08, `m_ready_i`=1 → `fifo_rd_en_o` high 8 consecutive cycles; `m_data_o` delivers 0x01..0x08 on 8 consecutive cycles starting 2 cycles after the first read.
- Preload 0x10..0x17, `m_ready_i`=0 for 20 cycles → exactly 2 reads issued, then `fifo_rd_en_o` stays 0; `m_data_o`=0x10 held stable; release ready → 0x10..0x17 in order, no bubbles after the first pop.
- Random `m_ready_i` (50%) with a random writer, 1000 words → scoreboard exact order, no loss or duplication, no read while `fifo_empty_i`=1, count never exceeds BUF_DEPTH.
- Assert `rst_i` 1 cycle during a read in flight with 2 buffered words → after reset `m_valid_o`=0, count=0, and the first word delivered after reset is the FIFO's next unread entry.
- FIFO_STREAM_READER_STATS_EN defined, `m_valid_o`=1 with `m_ready_i`=0 for 5 cycles → `stall_cnt_o`=5; reset → 0.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// Shared types for the SRAM-backed FIFO and its stream reader.
// No logic; types and width helpers only. No backpressure.
package sram_fifo_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    // Counter width able to hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flop_fifo.sv
// Small circular register buffer with head/tail pointers and an occupancy count.
// Latency: a pushed word becomes visible on head_dat the cycle after the push.
// Backpressure: none; the caller never pushes when full or pops when empty.
module flop_fifo
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2,
    localparam int CW = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_dat,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    tail_ptr;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail_ptr] <= push_dat;
                tail_ptr      <= ptr_inc(tail_ptr);
            end
            if (pop) begin
                head_ptr <= ptr_inc(head_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_dat = mem[head_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a one-cycle-latency FIFO into a valid/ready stream (optional stall counter: FIFO_STREAM_READER_STATS_EN).
// Latency: FIFO non-empty at N -> rd_en at N -> m_valid_o at N+2; then 1 word/cycle.
// Backpressure: reads are issued only when a buffer slot is guaranteed at data arrival.
module fifo_stream_reader
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             fifo_rd_en_o,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    output logic [31:0]      stall_cnt_o
`endif
);

    localparam int CW = cnt_width(BUF_DEPTH);

    logic          inflight_ff;
    logic [CW-1:0] buf_cnt;
    logic          pop;
    logic [CW:0]   occ_next;

    // Gating with rst_i keeps the FIFO untouched and the stream quiet while reset is held.
    assign m_valid_o = !rst_i && (buf_cnt != '0);
    assign pop       = m_valid_o && m_ready_i;
    assign occ_next  = {1'b0, buf_cnt} + (CW+1)'(inflight_ff) - (CW+1)'(pop);

    assign fifo_rd_en_o = !rst_i && !fifo_empty_i && (occ_next < (CW+1)'(BUF_DEPTH));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_ff <= 1'b0;
        end else begin
            inflight_ff <= fifo_rd_en_o;
        end
    end

    flop_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (inflight_ff),
        .pop      (pop),
        .push_dat (fifo_data_i),
        .head_dat (m_data_o),
        .count    (buf_cnt)
    );

`ifdef FIFO_STREAM_READER_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (m_valid_o && !m_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
